// File: rtl/act_table_loader.sv
// act_table_loader: runtime loader for the RNN activation lookup tables.
// A valid/ready stream fills the table in index order. Once the table is
// complete, it serves registered (latency-1) lookups to the activation
// layer. The table itself is a simple dual-port memory: one write port
// and one registered read port.
module act_table_loader #(
  parameter int MEM_WIDTH      = 10,
  parameter int TABLE_SIZE_POW = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_start,
  input  logic [MEM_WIDTH-1:0]      wr_data,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic                      rd_en,
  input  logic [TABLE_SIZE_POW-1:0] rd_addr,
  output logic [MEM_WIDTH-1:0]      rd_data,
  output logic                      rd_valid,
  output logic                      table_valid,
  output logic                      load_done,
  output logic                      load_abort,
  output logic [TABLE_SIZE_POW:0]   load_count
);

  localparam int TABLE_SIZE = 2 ** TABLE_SIZE_POW;

  localparam logic [TABLE_SIZE_POW-1:0] PTR_ZERO  = {TABLE_SIZE_POW{1'b0}};
  localparam logic [TABLE_SIZE_POW-1:0] PTR_ONE   = TABLE_SIZE_POW'(1);
  localparam logic [TABLE_SIZE_POW-1:0] PTR_LAST  = TABLE_SIZE_POW'(TABLE_SIZE - 1);
  localparam logic [TABLE_SIZE_POW:0]   CNT_ZERO  = {(TABLE_SIZE_POW + 1){1'b0}};
  localparam logic [TABLE_SIZE_POW:0]   CNT_ONE   = (TABLE_SIZE_POW + 1)'(1);
  localparam logic [TABLE_SIZE_POW:0]   CNT_FULL  = (TABLE_SIZE_POW + 1)'(TABLE_SIZE);
  localparam logic [MEM_WIDTH-1:0]      DATA_ZERO = {MEM_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  // Table storage; deliberately not cleared by reset so it maps onto BRAM.
  logic [MEM_WIDTH-1:0] mem [TABLE_SIZE];

  state_t                    state_q,       state_d;
  logic [TABLE_SIZE_POW-1:0] ptr_q,         ptr_d;
  logic [TABLE_SIZE_POW:0]   load_count_q,  load_count_d;
  logic                      table_valid_q, table_valid_d;
  logic                      load_done_q,   load_done_d;
  logic                      load_abort_q,  load_abort_d;
  logic [MEM_WIDTH-1:0]      rd_data_q,     rd_data_d;
  logic                      rd_valid_q,    rd_valid_d;

  logic                      wr_ready_c;
  logic                      wr_fire;
  logic                      mem_we;

  // A restart request takes precedence over a beat in the same cycle.
  assign wr_ready_c = (state_q == ST_LOAD) && !load_start;
  assign wr_fire    = wr_valid && wr_ready_c;

  // Next-state logic: load sequencing, pointer, entry count and status pulses.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    load_count_d  = load_count_q;
    table_valid_d = table_valid_q;
    load_done_d   = 1'b0;
    load_abort_d  = 1'b0;
    mem_we        = 1'b0;

    case (state_q)
      ST_EMPTY: begin
        ptr_d         = PTR_ZERO;
        load_count_d  = CNT_ZERO;
        table_valid_d = 1'b0;
        if (load_start) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_EMPTY;
        end
      end

      ST_LOAD: begin
        table_valid_d = 1'b0;
        if (load_start) begin
          // Restart mid-load: rewind without consuming the current beat.
          ptr_d        = PTR_ZERO;
          load_count_d = CNT_ZERO;
          load_abort_d = 1'b1;
        end else if (wr_fire) begin
          mem_we = 1'b1;
          if (ptr_q == PTR_LAST) begin
            // Last entry: pointer never wraps, the table becomes usable.
            state_d       = ST_READY;
            ptr_d         = PTR_ZERO;
            load_count_d  = CNT_FULL;
            table_valid_d = 1'b1;
            load_done_d   = 1'b1;
          end else begin
            ptr_d        = ptr_q + PTR_ONE;
            load_count_d = load_count_q + CNT_ONE;
          end
        end else begin
          // Bubble: hold pointer and count.
          ptr_d        = ptr_q;
          load_count_d = load_count_q;
        end
      end

      ST_READY: begin
        if (load_start) begin
          // Reload from a complete table: invalidate, no abort pulse.
          state_d       = ST_LOAD;
          ptr_d         = PTR_ZERO;
          load_count_d  = CNT_ZERO;
          table_valid_d = 1'b0;
        end else begin
          table_valid_d = 1'b1;
        end
      end

      default: begin
        state_d       = ST_EMPTY;
        ptr_d         = PTR_ZERO;
        load_count_d  = CNT_ZERO;
        table_valid_d = 1'b0;
      end
    endcase
  end

  // Lookup path: registered read, gated by the table state at request time.
  always_comb begin
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      if (table_valid_q) begin
        rd_valid_d = 1'b1;
        rd_data_d  = mem[rd_addr];
      end else begin
        rd_valid_d = 1'b0;
        rd_data_d  = DATA_ZERO;
      end
    end else begin
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
    end
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_EMPTY;
      ptr_q         <= PTR_ZERO;
      load_count_q  <= CNT_ZERO;
      table_valid_q <= 1'b0;
      load_done_q   <= 1'b0;
      load_abort_q  <= 1'b0;
      rd_data_q     <= DATA_ZERO;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      load_count_q  <= load_count_d;
      table_valid_q <= table_valid_d;
      load_done_q   <= load_done_d;
      load_abort_q  <= load_abort_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
    end
  end

  // Table write port; a reset in the same cycle suppresses the write.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem[ptr_q] <= wr_data;
    end
  end

  assign wr_ready    = wr_ready_c;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign table_valid = table_valid_q;
  assign load_done   = load_done_q;
  assign load_abort  = load_abort_q;
  assign load_count  = load_count_q;

endmodule

// File: tb/tb_act_table_loader.sv
// Scoreboard bench for act_table_loader (TABLE_SIZE_POW=4, MEM_WIDTH=10).
// Lookup expectations are queued at request time and checked by a separate
// monitor; load status is checked directly by the stimulus.
module tb_act_table_loader;

  localparam int MW = 10;
  localparam int TP = 4;

  typedef struct packed {
    logic          v;
    logic [MW-1:0] d;
  } rd_exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start;
  logic [MW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic          rd_en;
  logic [TP-1:0] rd_addr;
  logic [MW-1:0] rd_data;
  logic          rd_valid;
  logic          table_valid;
  logic          load_done;
  logic          load_abort;
  logic [TP:0]   load_count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  rd_exp_t exp_q[$];

  act_table_loader #(.MEM_WIDTH(MW), .TABLE_SIZE_POW(TP)) dut (
    .clk(clk), .reset(reset), .load_start(load_start),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .table_valid(table_valid), .load_done(load_done),
    .load_abort(load_abort), .load_count(load_count)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MW-1:0] beat_data(input int mode, input int i);
    case (mode)
      0:       beat_data = 10'(10'h010 + i);
      1:       beat_data = 10'(10'h200 + i);
      default: beat_data = 10'(10'h3FF - i);
    endcase
  endfunction

  task automatic rd_req(input logic [TP-1:0] a, input logic v, input logic [MW-1:0] d);
    rd_en   = 1'b1;
    rd_addr = a;
    exp_q.push_back({v, d});
    step();
    rd_en = 1'b0;
  endtask

  task automatic load_beats(input int mode, input bit do_start, input bit gaps, input int nbeats);
    if (do_start) begin
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      chk("start_no_abort", load_abort, 0);
      chk("start_tv_low", table_valid, 0);
      chk("start_count0", load_count, 0);
    end
    for (int i = 0; i < nbeats; i++) begin
      wr_valid = 1'b1;
      wr_data  = beat_data(mode, i);
      if (i == 15) begin
        // Lookup coinciding with the final write still sees an invalid table.
        rd_en   = 1'b1;
        rd_addr = 4'd0;
        exp_q.push_back({1'b0, 10'h000});
      end
      #1;
      chk("wr_ready_load", wr_ready, 1);
      step();
      rd_en = 1'b0;
      if (gaps) begin
        chk("count_step", load_count, i + 1);
        if (i != 15) chk("no_early_done", load_done, 0);
      end
      if (gaps && i != nbeats - 1) begin
        wr_valid = 1'b0;
        step();
        chk("count_bubble", load_count, i + 1);
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic finish_check();
    chk("load_done_pulse", load_done, 1);
    chk("table_valid_set", table_valid, 1);
    chk("load_count_full", load_count, 16);
    step();
    chk("load_done_once", load_done, 0);
    chk("table_valid_hold", table_valid, 1);
  endtask

  // Monitor: compares each lookup response against the scoreboard queue.
  initial begin
    logic          req;
    logic          rst_seen;
    logic [MW-1:0] last_data;
    rd_exp_t       e;
    last_data = 10'h000;
    forever begin
      @(posedge clk);
      req      = rd_en && !reset;
      rst_seen = reset;
      @(negedge clk);
      if (rst_seen) begin
        last_data = 10'h000;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
      end else if (req) begin
        if (exp_q.size() == 0) begin
          chk("rd_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_valid", rd_valid, e.v);
          chk("rd_data", rd_data, e.d);
          last_data = e.d;
        end
      end else begin
        chk("rd_valid_idle", rd_valid, 0);
        chk("rd_data_hold", rd_data, last_data);
      end
    end
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Directed scenarios.
  initial begin
    reset = 1'b1; load_start = 1'b0; wr_data = 10'h000; wr_valid = 1'b0;
    rd_en = 1'b0; rd_addr = 4'd0;
    step(); step();
    reset = 1'b0;

    // 1: reset state and lookup on an empty table.
    chk("rst_table_valid", table_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_load_abort", load_abort, 0);
    chk("rst_load_count", load_count, 0);
    rd_req(4'd3, 1'b0, 10'h000);

    // 2: gapless load of 0x10+i.
    load_beats(0, 1'b1, 1'b0, 16);
    finish_check();
    rd_req(4'd0,  1'b1, 10'h010);
    rd_req(4'd5,  1'b1, 10'h015);
    step();
    rd_req(4'd15, 1'b1, 10'h01F);

    // 3: reload with a bubble between every beat.
    load_beats(0, 1'b1, 1'b1, 16);
    finish_check();
    rd_req(4'd9, 1'b1, 10'h019);
    rd_req(4'd0, 1'b1, 10'h010);

    // 4: restart after 7 beats with a beat offered at the same time.
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_beats(0, 1'b0, 1'b0, 7);
    chk("count_7", load_count, 7);
    load_start = 1'b1;
    wr_valid   = 1'b1;
    wr_data    = 10'h155;
    #1;
    chk("restart_wr_ready", wr_ready, 0);
    step();
    load_start = 1'b0;
    wr_valid   = 1'b0;
    chk("abort_pulse", load_abort, 1);
    chk("abort_count0", load_count, 0);
    step();
    chk("abort_once", load_abort, 0);
    load_beats(1, 1'b0, 1'b0, 16);
    finish_check();
    rd_req(4'd2, 1'b1, 10'h202);
    rd_req(4'd7, 1'b1, 10'h207);

    // 5: stray beats in READY ignored; reload invalidates the table.
    wr_valid = 1'b1;
    wr_data  = 10'h0AA;
    step(); step();
    wr_valid = 1'b0;
    chk("ready_count_hold", load_count, 16);
    chk("ready_tv_hold", table_valid, 1);
    rd_req(4'd0, 1'b1, 10'h200);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("reload_tv_drop", table_valid, 0);
    chk("reload_no_abort", load_abort, 0);
    chk("reload_count0", load_count, 0);
    rd_req(4'd4, 1'b0, 10'h000);

    // 6: reset in the middle of a load, then a full load of 0x3FF-i.
    load_beats(1, 1'b0, 1'b0, 9);
    chk("count_9", load_count, 9);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_tv", table_valid, 0);
    chk("midrst_count", load_count, 0);
    chk("midrst_wr_ready", wr_ready, 0);
    rd_req(4'd0, 1'b0, 10'h000);
    load_beats(2, 1'b1, 1'b0, 16);
    finish_check();
    rd_req(4'd0,  1'b1, 10'h3FF);
    rd_req(4'd15, 1'b1, 10'h3F0);
    rd_req(4'd8,  1'b1, 10'h3F7);

    step(); step(); step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
